// File: rtl/types_pkg.sv
// Shared micro-architectural types: the ROB entry record and the ROB sizing
// constants, so that rename, reservation-station and ROB users size tags alike.
package types_pkg;

  // The rob_index field is 5 bits wide, so the ROB can hold at most 32 entries.
  localparam int ROB_IDX_W = 5;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic                 complete;
    logic [7:0]           pd_new;
    logic [7:0]           pd_old;
    logic [31:0]          pc;
    logic [ROB_IDX_W-1:0] rob_index;
  } rob_data;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of the ROB's allocate, complete, commit and status signals.
// master = surrounding pipeline (rename / writeback / retire consumer), slave = ROB.
interface reorder_buffer_if #(
  parameter int TAG_W = 4
);

  logic             alloc_valid;
  logic             alloc_ready;
  logic [7:0]       alloc_pd_new;
  logic [7:0]       alloc_pd_old;
  logic [31:0]      alloc_pc;
  logic [TAG_W-1:0] alloc_tag;

  logic             cmpl_valid;
  logic [TAG_W-1:0] cmpl_tag;

  logic             commit_valid;
  logic             commit_ready;
  logic [7:0]       commit_pd_old;
  logic [7:0]       commit_pd_new;
  logic [31:0]      commit_pc;
  logic [TAG_W-1:0] commit_tag;

  logic             flush;
  logic [TAG_W:0]   count;
  logic             full;
  logic             empty;

  modport master (
    output alloc_valid, alloc_pd_new, alloc_pd_old, alloc_pc,
    input  alloc_ready, alloc_tag,
    output cmpl_valid, cmpl_tag,
    input  commit_valid, commit_pd_old, commit_pd_new, commit_pc, commit_tag,
    output commit_ready, flush,
    input  count, full, empty
  );

  modport slave (
    input  alloc_valid, alloc_pd_new, alloc_pd_old, alloc_pc,
    output alloc_ready, alloc_tag,
    input  cmpl_valid, cmpl_tag,
    output commit_valid, commit_pd_old, commit_pd_new, commit_pc, commit_tag,
    input  commit_ready, flush,
    output count, full, empty
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at the tail in program order, marks
// entries complete by tag, and retires the oldest completed entry at the head.
module reorder_buffer
  import types_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  reorder_buffer_if.slave  rob
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]   head_q, head_d;
  logic [TAG_W:0]   tail_q, tail_d;
  rob_data          entries_q [DEPTH];
  rob_data          entries_d [DEPTH];

  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             full;
  logic             alloc_fire;
  logic             commit_fire;
  rob_data          head_entry;
  logic             unused_idx_bits;

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  assign head_entry = entries_q[head_idx];

  // Status and handshake outputs, all derived from registered state only.
  always_comb begin
    full              = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    rob.full          = full;
    rob.empty         = (head_q == tail_q);
    rob.count         = tail_q - head_q;
    rob.alloc_ready   = !full;
    rob.alloc_tag     = tail_idx;
    rob.commit_valid  = head_entry.valid && head_entry.complete;
    rob.commit_pd_old = '0;
    rob.commit_pd_new = '0;
    rob.commit_pc     = '0;
    rob.commit_tag    = '0;
    if (rob.commit_valid) begin
      rob.commit_pd_old = head_entry.pd_old;
      rob.commit_pd_new = head_entry.pd_new;
      rob.commit_pc     = head_entry.pc;
      rob.commit_tag    = head_entry.rob_index[TAG_W-1:0];
    end
  end

  assign alloc_fire      = rob.alloc_valid && !full;
  assign commit_fire     = rob.commit_valid && rob.commit_ready;
  // Only the low TAG_W bits of rob_index are meaningful for this depth.
  assign unused_idx_bits = ^head_entry.rob_index;

  // Next-state: flush wins; otherwise completion, commit and allocation combine.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;

    if (rob.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid    = 1'b0;
        entries_d[i].complete = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      // A retiring entry is already complete, so a completion aimed at it is dropped.
      if (rob.cmpl_valid && entries_q[rob.cmpl_tag].valid &&
          !(commit_fire && (rob.cmpl_tag == head_idx))) begin
        entries_d[rob.cmpl_tag].complete = 1'b1;
      end

      if (commit_fire) begin
        entries_d[head_idx].valid    = 1'b0;
        entries_d[head_idx].complete = 1'b0;
        head_d = head_q + 1'b1;
      end

      // The tail slot is never the committing head unless the ROB is full,
      // and allocation is blocked when full, so these writes cannot collide.
      if (alloc_fire) begin
        entries_d[tail_idx].valid     = 1'b1;
        entries_d[tail_idx].complete  = 1'b0;
        entries_d[tail_idx].pd_new    = rob.alloc_pd_new;
        entries_d[tail_idx].pd_old    = rob.alloc_pd_old;
        entries_d[tail_idx].pc        = rob.alloc_pc;
        entries_d[tail_idx].rob_index = ROB_IDX_W'(tail_idx);
        tail_d = tail_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      // NOTE: the entry array is flops, not RAM, so it is cleared on reset;
      // valid/complete must start at zero and a RAM could not clear them in parallel.
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      head_q    <= head_d;
      tail_q    <= tail_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer holding in-flight instructions in program order, built from types_pkg::rob_data entries.
- The rename stage writes entries: one allocation per cycle, returning the allocated tag.
- Functional-unit writeback marks entries complete by tag.
- This block is the reader/retire end: it commits the oldest completed entry in order and hands pd_old to the free list for release.

Parameters:
DEPTH, 16, number of entries; power of two, 2..32 (limited by the 5-bit rob_index field).
TAG_W, $clog2(DEPTH), width of the ROB tag/index.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
alloc_valid  input  1  rename presents a new instruction.
alloc_ready  output  1  ROB can accept an allocation this cycle.
alloc_pd_new  input  8  destination physical register of the new instruction.
alloc_pd_old  input  8  previous mapping of rd, freed at commit.
alloc_pc  input  32  PC of the instruction.
alloc_tag  output  TAG_W  tag assigned on a handshake; equals the tail index.
cmpl_valid  input  1  writeback completion strobe.
cmpl_tag  input  TAG_W  tag of the completing entry.
commit_valid  output  1  head entry is valid and complete.
commit_ready  input  1  consumer (free list / arch map) accepts the commit.
commit_pd_old  output  8  physical register to free.
commit_pd_new  output  8  physical register becoming architectural.
commit_pc  output  32  PC of the committing instruction.
commit_tag  output  TAG_W  index of the committing entry.
flush  input  1  discard all in-flight entries.
count  output  TAG_W+1  number of valid entries.
full  output  1  count == DEPTH.
empty  output  1  count == 0.

Behaviour:
- Storage: DEPTH x rob_data. Fields used: valid, complete, pd_new, pd_old, pc, rob_index (= slot index).
- Pointers: head/tail of TAG_W+1 bits, with the MSB as a wrap bit.
  - empty when head == tail.
  - full when indices are equal and wrap bits differ.
  - count = tail - head, modulo 2^(TAG_W+1).
- Reset (asynchronous, reset_n=0):
  - All valid/complete bits cleared; head = tail = 0.
  - Outputs: alloc_ready=1, alloc_tag=0, commit_valid=0, commit_* = 0, count=0, empty=1, full=0.
- Allocation:
  - alloc_ready = !full, purely combinational.
  - No same-cycle commit bypass: when full, alloc_ready=0 even if a commit fires that cycle.
  - On alloc_valid && alloc_ready: entry[tail] <= {valid=1, complete=0, fields, rob_index=tail}; tail increments and wraps via the MSB.
  - alloc_tag = tail index at all times.
- Completion:
  - On cmpl_valid, if entry[cmpl_tag].valid, set complete=1 at the next edge.
  - Completion to an invalid entry is ignored, with no other state change.
  - A duplicate completion is harmless.
- Commit:
  - commit_valid = entry[head].valid && entry[head].complete, combinational from registered state.
  - commit_* fields mirror entry[head] when commit_valid=1 and are forced to 0 otherwise.
  - On commit_valid && commit_ready: entry[head].valid <= 0, complete <= 0, head increments.
  - At most one commit per cycle. commit_valid must not drop while commit_ready=0 (no flush).
- Latency:
  - Allocation at edge N, completion strobe presented in cycle N+1 at the earliest.
  - complete bit set at edge N+2; commit_valid high in cycle N+2.
- Simultaneous events:
  - Allocation and commit in the same cycle are both performed; count is unchanged.
  - A completion targeting the head while it is not yet complete: commit_valid rises the next cycle.
  - A completion arriving in the same cycle the entry retires cannot occur, since a retiring entry is already complete. If it does occur, it is ignored.
- Flush:
  - Synchronous; takes priority over allocation, completion and commit in the same cycle.
  - Next edge: all valid/complete cleared, head = tail = 0.
  - Outputs then return to their reset values.
- Reset mid-operation: asynchronous clear regardless of any handshake in progress; no partial commit is emitted.

Decomposition:
- types_pkg already holds rob_data. Add ROB_DEPTH (=16) and ROB_TAG_W as package localparams so that rename and rs_data users size tags consistently.
- Single module, no sub-module required. Pointer arithmetic is local; the storage array is inferred registers, because completion is a random-access write and valid bits need a parallel clear.

Test Plan:
1. Reset, then allocate 3 entries (pc 0x100/0x104/0x108) with no completions -> alloc_tag 0,1,2; count=3; commit_valid stays 0.
2. Complete tags 2 then 1, head (tag 0) incomplete -> commit_valid=0. Then complete tag 0 -> commit_valid next cycle. With commit_ready=1, commits tags 0,1,2 on consecutive cycles with commit_pd_old matching the allocated values.
3. Allocate 16 entries -> full=1, alloc_ready=0. A 17th alloc_valid is not accepted. Complete+commit one entry -> alloc_ready=1 the following cycle, and the next allocation receives tag 0 (wrap).
4. Head complete, commit_ready=0 for 4 cycles -> commit_valid held at 1 with stable fields; no head movement; count unchanged.
5. Allocate and commit in the same cycle with count=5 -> count remains 5; the head and tail pointers each advance by 1.
6. 8 valid entries: assert flush concurrently with alloc_valid and cmpl_valid -> next cycle empty=1, count=0, alloc_tag=0, commit_valid=0. Assert reset_n low mid-commit -> outputs reset immediately, before the clock edge.
